// File: rtl/cgra_obi_mem_responder.sv
// OBI responder with a word-addressed scratchpad, programmable grant wait states and a fixed-depth
// response pipe; used as CGRA-local memory and as a latency/back-pressure model for OBI initiators.
module cgra_obi_mem_responder #(
    parameter int unsigned NUM_WORDS    = 1024,
    parameter int unsigned WAIT_CYCLES  = 0,
    parameter int unsigned RESP_LATENCY = 1,
    parameter logic [31:0] ERR_RDATA    = 32'hBADCAB1E
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic [15:0] err_cnt_o
);

    localparam int unsigned IDX_W     = $clog2(NUM_WORDS);
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES);
    localparam logic [29:0] DEPTH     = 30'(NUM_WORDS);

    logic [3:0]              wcnt_q, wcnt_d;
    logic [15:0]             err_cnt_q, err_cnt_d;
    logic                    accept;
    logic                    in_range;
    logic [IDX_W-1:0]        idx;
    logic [31:0]             resp_dat;
    logic [31:0]             mem_q [NUM_WORDS];
    logic [RESP_LATENCY-1:0] pvld_q;
    logic [31:0]             pdat_q [RESP_LATENCY];

    // Grant is gated by reset so no request can be accepted while the pipe is being cleared.
    assign gnt_o    = req_i && rst_ni && (wcnt_q == WAIT_LAST);
    assign accept   = req_i && gnt_o;
    assign in_range = addr_i[31:2] < DEPTH;
    assign idx      = addr_i[IDX_W+1:2];

    always_comb begin
        wcnt_d = wcnt_q;
        if (!req_i || accept) begin
            wcnt_d = '0;
        end else if (wcnt_q != WAIT_LAST) begin
            wcnt_d = wcnt_q + 4'd1;
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && !in_range && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Reads sample the array before this edge's own update, which already holds every earlier write.
    always_comb begin
        resp_dat = '0;
        if (!in_range) begin
            resp_dat = we_i ? 32'h0 : ERR_RDATA;
        end else if (!we_i) begin
            resp_dat = mem_q[idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && in_range && we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wcnt_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            wcnt_q    <= wcnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Data is zeroed alongside valid so the output data is 0 whenever no response is presented.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pvld_q <= '0;
            for (int i = 0; i < int'(RESP_LATENCY); i++) begin
                pdat_q[i] <= '0;
            end
        end else begin
            pvld_q[0] <= accept;
            pdat_q[0] <= accept ? resp_dat : 32'h0;
            for (int i = 1; i < int'(RESP_LATENCY); i++) begin
                pvld_q[i] <= pvld_q[i-1];
                pdat_q[i] <= pdat_q[i-1];
            end
        end
    end

    assign rvalid_o  = pvld_q[RESP_LATENCY-1];
    assign rdata_o   = pdat_q[RESP_LATENCY-1];
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_cgra_obi_mem_responder.sv
// Bench for cgra_obi_mem_responder: three instances with different wait/latency settings, each
// checked every cycle against a transaction-level model of memory, grant timing and response schedule.
module tb_cgra_obi_mem_responder;

    localparam int          NW   = 16;
    localparam logic [31:0] ERRD = 32'hBADCAB1E;
    localparam int          WP [3] = '{0, 3, 0};
    localparam int          LP [3] = '{1, 2, 4};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req [3];
    logic        we [3];
    logic [3:0]  be [3];
    logic [31:0] addr [3];
    logic [31:0] wdata [3];
    logic        gnt [3];
    logic        rvalid [3];
    logic [31:0] rdata [3];
    logic [15:0] errc [3];

    always #5 clk = ~clk;

    cgra_obi_mem_responder #(.NUM_WORDS(NW), .WAIT_CYCLES(0), .RESP_LATENCY(1), .ERR_RDATA(ERRD)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .we_i(we[0]), .be_i(be[0]), .addr_i(addr[0]),
        .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_cnt_o(errc[0]));
    cgra_obi_mem_responder #(.NUM_WORDS(NW), .WAIT_CYCLES(3), .RESP_LATENCY(2), .ERR_RDATA(ERRD)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .we_i(we[1]), .be_i(be[1]), .addr_i(addr[1]),
        .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_cnt_o(errc[1]));
    cgra_obi_mem_responder #(.NUM_WORDS(NW), .WAIT_CYCLES(0), .RESP_LATENCY(4), .ERR_RDATA(ERRD)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .we_i(we[2]), .be_i(be[2]), .addr_i(addr[2]),
        .wdata_i(wdata[2]), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_cnt_o(errc[2]));

    // Reference model: memory image, cycles a request has waited, error count, and a
    // per-cycle calendar of the response each instance owes.
    logic [31:0] mm [3][NW];
    int          held [3];
    logic [15:0] em [3];
    logic        sv [3][64];
    logic [31:0] sd [3][64];
    int          cyc;
    int          nvec = 0;
    int          nerr = 0;

    logic        og, eg, orv, erv;
    logic [31:0] ord, erd;
    logic [15:0] oe, ee;

    task automatic clear_model();
        for (int d = 0; d < 3; d++) begin
            held[d] = 0;
            em[d]   = 16'h0;
            for (int s = 0; s < 64; s++) begin
                sv[d][s] = 1'b0;
                sd[d][s] = 32'h0;
            end
        end
    endtask

    // Applies one cycle of inputs to instance d, captures observed outputs and model expectations.
    task automatic step(input int d, input logic r, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] rd;
        int          s;
        req[d] = r; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
        @(negedge clk);
        og = gnt[d]; orv = rvalid[d]; ord = rdata[d]; oe = errc[d];
        s   = cyc % 64;
        eg  = r && (held[d] == WP[d]);
        erv = sv[d][s];
        erd = sv[d][s] ? sd[d][s] : 32'h0;
        ee  = em[d];
        sv[d][s] = 1'b0;
        if (eg) begin
            rd = 32'h0;
            if (a[31:2] < 30'(NW)) begin
                if (w) begin
                    for (int k = 0; k < 4; k++) begin
                        if (b[k]) mm[d][a[5:2]][8*k +: 8] = wd[8*k +: 8];
                    end
                end else begin
                    rd = mm[d][a[5:2]];
                end
            end else begin
                if (!w) rd = ERRD;
                if (em[d] != 16'hFFFF) em[d] = em[d] + 16'd1;
            end
            sv[d][(cyc + LP[d]) % 64] = 1'b1;
            sd[d][(cyc + LP[d]) % 64] = rd;
            held[d] = 0;
        end else begin
            held[d] = r ? held[d] + 1 : 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            nvec++;
            if ({gnt[d], rvalid[d], rdata[d], errc[d]} !== 50'h0) begin
                nerr++;
                $display("FAIL reset d%0d: got gnt=%b rv=%b rd=%h err=%0d, want all 0", d, gnt[d], rvalid[d], rdata[d], errc[d]);
            end
        end
    endtask

    task automatic test_preload();
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < NW; i++) begin
                logic [31:0] v;
                int          g;
                v = (i < 4) ? 32'(i) : $urandom;
                g = 0;
                do begin
                    step(d, 1'b1, 1'b1, 4'hF, 32'(i * 4), v);
                    nvec++;
                    if ({og, orv, ord, oe} !== {eg, erv, erd, ee}) begin
                        nerr++;
                        $display("FAIL preload d%0d cyc%0d: got g=%b v=%b d=%h e=%0d want g=%b v=%b d=%h e=%0d", d, cyc, og, orv, ord, oe, eg, erv, erd, ee);
                    end
                    g++;
                end while (!eg && g < 8);
            end
            for (int i = 0; i < 6; i++) begin
                step(d, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
                nvec++;
                if ({og, orv, ord, oe} !== {eg, erv, erd, ee}) begin
                    nerr++;
                    $display("FAIL preload_drain d%0d cyc%0d: got v=%b d=%h want v=%b d=%h", d, cyc, orv, ord, erv, erd);
                end
            end
        end
    endtask

    task automatic test_write_read();
        logic [33:0] want [4];
        want[0] = {1'b1, 1'b0, 32'h0};
        want[1] = {1'b1, 1'b1, 32'h0};
        want[2] = {1'b0, 1'b1, 32'hDEADBEEF};
        want[3] = {1'b0, 1'b0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       step(0, 1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
                1:       step(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
                default: step(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            endcase
            nvec++;
            if ({og, orv, ord} !== want[i]) begin
                nerr++;
                $display("FAIL write_read step%0d: got g=%b v=%b d=%h want %h", i, og, orv, ord, want[i]);
            end
            nvec++;
            if ({og, orv, ord, oe} !== {eg, erv, erd, ee}) begin
                nerr++;
                $display("FAIL write_read_model step%0d: got v=%b d=%h want v=%b d=%h", i, orv, ord, erv, erd);
            end
        end
    endtask

    task automatic test_byte_en();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       step(0, 1'b1, 1'b1, 4'hF, 32'h0, 32'h11223344);
                1:       step(0, 1'b1, 1'b1, 4'b0101, 32'h0, 32'hAABBCCDD);
                2:       step(0, 1'b1, 1'b0, 4'hF, 32'h3, 32'h0);
                default: step(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            endcase
            nvec++;
            if ({og, orv, ord, oe} !== {eg, erv, erd, ee}) begin
                nerr++;
                $display("FAIL byte_en_model step%0d: got v=%b d=%h want v=%b d=%h", i, orv, ord, erv, erd);
            end
            if (i == 3) begin
                nvec++;
                if ({orv, ord} !== {1'b1, 32'h11BB33DD}) begin
                    nerr++;
                    $display("FAIL byte_en_data: got v=%b d=%h want v=1 d=11bb33dd", orv, ord);
                end
            end
        end
    endtask

    task automatic test_wait();
        // Held 4 cycles, then held 2 and dropped for 1, then held 4 again.
        logic rq [11] = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1};
        logic gw [11] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
        for (int i = 0; i < 15; i++) begin
            if (i < 11) step(1, rq[i], 1'b0, 4'hF, 32'h8, 32'h0);
            else        step(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            if (i < 11) begin
                nvec++;
                if (og !== gw[i]) begin
                    nerr++;
                    $display("FAIL wait_gnt cycle%0d: got %b want %b", i, og, gw[i]);
                end
            end
            nvec++;
            if ({og, orv, ord, oe} !== {eg, erv, erd, ee}) begin
                nerr++;
                $display("FAIL wait_model cycle%0d: got g=%b v=%b d=%h want g=%b v=%b d=%h", i, og, orv, ord, eg, erv, erd);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            logic [32:0] want;
            if (i < 4) step(2, 1'b1, 1'b0, 4'hF, 32'(i * 4), 32'h0);
            else       step(2, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            want = (i >= 4 && i < 8) ? {1'b1, 32'(i - 4)} : 33'h0;
            nvec++;
            if ({orv, ord} !== want) begin
                nerr++;
                $display("FAIL back_to_back cycle%0d: got v=%b d=%h want %h", i, orv, ord, want);
            end
            nvec++;
            if ({og, orv, ord, oe} !== {eg, erv, erd, ee}) begin
                nerr++;
                $display("FAIL back_to_back_model cycle%0d: got g=%b v=%b d=%h want g=%b v=%b d=%h", i, og, orv, ord, eg, erv, erd);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [48:0] want [6];
        want[0] = {1'b0, 32'h0, 16'd0};
        want[1] = {1'b1, ERRD, 16'd1};
        want[2] = {1'b0, 32'h0, 16'd1};
        want[3] = {1'b1, 32'h0, 16'd2};
        want[4] = {1'b0, 32'h0, 16'd2};
        want[5] = {1'b1, 32'h11BB33DD, 16'd2};
        for (int i = 0; i < 6; i++) begin
            case (i)
                0:       step(0, 1'b1, 1'b0, 4'hF, 32'(NW * 4), 32'h0);
                2:       step(0, 1'b1, 1'b1, 4'hF, 32'(NW * 4 + 4), 32'hFFFFFFFF);
                4:       step(0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
                default: step(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            endcase
            nvec++;
            if ({orv, ord, oe} !== want[i]) begin
                nerr++;
                $display("FAIL out_of_range step%0d: got v=%b d=%h e=%0d want %h", i, orv, ord, oe, want[i]);
            end
            nvec++;
            if ({og, orv, ord, oe} !== {eg, erv, erd, ee}) begin
                nerr++;
                $display("FAIL out_of_range_model step%0d: got e=%0d d=%h want e=%0d d=%h", i, oe, ord, ee, erd);
            end
        end
    endtask

    task automatic test_random();
        logic        r, w, pend;
        logic [3:0]  b;
        logic [31:0] a, wd;
        for (int d = 0; d < 3; d++) begin
            pend = 1'b0; r = 1'b0; w = 1'b0; b = 4'h0; a = 32'h0; wd = 32'h0;
            for (int n = 0; n < 206; n++) begin
                if (n >= 200) begin
                    r = 1'b0;
                end else if (!(pend && $urandom_range(9) != 0)) begin
                    r  = ($urandom_range(3) != 0);
                    w  = $urandom_range(1) == 1;
                    b  = 4'($urandom_range(15));
                    a  = 32'($urandom_range(NW * 4 + 15));
                    wd = $urandom;
                end
                step(d, r, w, b, a, wd);
                pend = r && !eg;
                nvec++;
                if ({og, orv, ord, oe} !== {eg, erv, erd, ee}) begin
                    nerr++;
                    $display("FAIL random d%0d cyc%0d: got g=%b v=%b d=%h e=%0d want g=%b v=%b d=%h e=%0d", d, cyc, og, orv, ord, oe, eg, erv, erd, ee);
                end
            end
        end
    endtask

    task automatic test_reset_inflight();
        for (int i = 0; i < 4; i++) begin
            step(2, 1'b1, 1'b0, 4'hF, 32'((i + 1) * 4), 32'h0);
            nvec++;
            if ({og, orv, ord, oe} !== {eg, erv, erd, ee}) begin
                nerr++;
                $display("FAIL inflight_model cycle%0d: got v=%b d=%h want v=%b d=%h", i, orv, ord, erv, erd);
            end
        end
        req[2] = 1'b0;
        nvec++;
        if ({rvalid[2], rdata[2]} !== {1'b1, mm[2][1]}) begin
            nerr++;
            $display("FAIL inflight_before_reset: got v=%b d=%h want v=1 d=%h", rvalid[2], rdata[2], mm[2][1]);
        end
        req[0] = 1'b1;
        rst_n  = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            nvec++;
            if ({gnt[d], rvalid[d], rdata[d], errc[d]} !== 50'h0) begin
                nerr++;
                $display("FAIL inflight_reset d%0d: got g=%b v=%b d=%h e=%0d want all 0", d, gnt[d], rvalid[d], rdata[d], errc[d]);
            end
        end
        req[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc += 2;
        rst_n = 1'b1;
        clear_model();
        for (int i = 0; i < 6; i++) begin
            step(2, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            nvec++;
            if ({orv, ord} !== 33'h0) begin
                nerr++;
                $display("FAIL inflight_after_release cycle%0d: got v=%b d=%h want v=0 d=0", i, orv, ord);
            end
        end
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < NW + 6; i++) begin
                int g;
                g = 0;
                do begin
                    if (i < NW) step(d, 1'b1, 1'b0, 4'hF, 32'(i * 4), 32'h0);
                    else        step(d, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
                    nvec++;
                    if ({og, orv, ord, oe} !== {eg, erv, erd, ee}) begin
                        nerr++;
                        $display("FAIL readback d%0d cyc%0d: got v=%b d=%h want v=%b d=%h", d, cyc, orv, ord, erv, erd);
                    end
                    g++;
                end while (i < NW && !eg && g < 8);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        cyc   = 0;
        for (int d = 0; d < 3; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; be[d] = 4'h0; addr[d] = 32'h0; wdata[d] = 32'h0;
        end
        clear_model();
        req[0] = 1'b1;
        #2;
        test_reset();
        req[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_preload();
        test_write_read();
        test_byte_en();
        test_wait();
        test_back_to_back();
        test_out_of_range();
        test_random();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
